// File: rtl/result_drain.sv
// Read-side drain engine: walks the output SRAM from a base address and streams each
// word to a valid/ready sink through a 2-entry skid FIFO with credit-based read issue.
module result_drain #(
  parameter int unsigned Addr_Width        = 4,
  parameter int unsigned Ram_Depth         = 1 << Addr_Width,
  parameter int unsigned Nums_Data_in_bits = 4,
  parameter int unsigned Para_Deg          = 1,
  parameter int unsigned Data_Width_Out    = 16
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic [Addr_Width-1:0]              Base_Addr,
  input  logic [Nums_Data_in_bits:0]         Count,
  output logic                               En_Chip_Select,
  output logic                               En_Read,
  output logic [Addr_Width-1:0]              Addr_Read,
  input  logic [Para_Deg*Data_Width_Out-1:0] Read_Data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [Para_Deg*Data_Width_Out-1:0] out_data,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned WordW = Para_Deg * Data_Width_Out;
  localparam int unsigned CntW  = Nums_Data_in_bits + 1;

  typedef enum logic [1:0] {StIdle, StIssue, StFlush, StDone} state_e;

  state_e                 state_q;
  logic [Addr_Width-1:0]  addr_q;
  logic [CntW-1:0]        cnt_q;
  logic                   rd_pend_q;
  logic                   rd_last_q;

  logic [WordW-1:0]       fifo_data_q [2];
  logic [1:0]             fifo_last_q;
  logic                   rd_ptr_q;
  logic                   wr_ptr_q;
  logic [1:0]             occ_q;

  logic                   pop;
  logic                   push;
  logic                   credit_ok;
  logic                   issue;
  logic                   final_issue;
  logic [1:0]             occ_next;
  logic [Addr_Width-1:0]  addr_inc;

  // Read data returns one cycle after the strobe and is pushed unconditionally.
  assign push = rd_pend_q;
  assign pop  = out_valid & out_ready;

  // occ + inflight - pop < 2, rearranged to avoid unsigned underflow.
  assign credit_ok = ({1'b0, occ_q} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, pop});
  assign issue       = (state_q == StIssue) && credit_ok;
  assign final_issue = issue && (cnt_q == CntW'(1));
  assign occ_next    = occ_q + {1'b0, push} - {1'b0, pop};

  assign addr_inc = (addr_q == Addr_Width'(Ram_Depth - 1)) ? '0 : addr_q + Addr_Width'(1);

  always_comb begin
    En_Read        = issue;
    En_Chip_Select = issue;
    Addr_Read      = addr_q;
    out_valid      = (occ_q != 2'd0);
    out_data       = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    out_last       = out_valid & fifo_last_q[rd_ptr_q];
    busy           = (state_q == StIssue) || (state_q == StFlush);
    done           = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      rd_pend_q <= issue;
      rd_last_q <= final_issue;
      if (issue) begin
        addr_q <= addr_inc;
        cnt_q  <= cnt_q - CntW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            addr_q  <= Base_Addr;
            cnt_q   <= Count;
            state_q <= (Count != '0) ? StIssue : StDone;
          end
        end
        StIssue: begin
          if (final_issue) state_q <= StFlush;
        end
        StFlush: begin
          // Leave on the edge that retires the last word so done follows that handshake.
          if (!rd_pend_q && (occ_next == 2'd0)) state_q <= StDone;
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      rd_ptr_q       <= 1'b0;
      wr_ptr_q       <= 1'b0;
      occ_q          <= 2'd0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= Read_Data;
        fifo_last_q[wr_ptr_q] <= rd_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_next;
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: SRAM model, queue-based expected stream,
// directed and randomized drains with handshake, timing and stall checks.
module tb_result_drain;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  Base_Addr;
  logic [4:0]  Count;
  logic        En_Chip_Select;
  logic        En_Read;
  logic [3:0]  Addr_Read;
  logic [15:0] Read_Data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] sram [16];
  int          n_total = 0;
  int          n_pass  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (En_Read) Read_Data <= sram[Addr_Read];

  result_drain dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .Base_Addr      (Base_Addr),
    .Count          (Count),
    .En_Chip_Select (En_Chip_Select),
    .En_Read        (En_Read),
    .Addr_Read      (Addr_Read),
    .Read_Data      (Read_Data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_last       (out_last),
    .busy           (busy),
    .done           (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en"},    {31'd0, En_Read},        0);
    check({tag, "_cs"},    {31'd0, En_Chip_Select}, 0);
    check({tag, "_addr"},  {28'd0, Addr_Read},      0);
    check({tag, "_valid"}, {31'd0, out_valid},      0);
    check({tag, "_data"},  {16'd0, out_data},       0);
    check({tag, "_last"},  {31'd0, out_last},       0);
    check({tag, "_busy"},  {31'd0, busy},           0);
    check({tag, "_done"},  {31'd0, done},           0);
  endtask

  // mode: 0 ready held high (cycle-exact checks), 1 ready pattern 1,0,0,1, 2 random ready.
  // restart_at: cycle to pulse a competing start (0 = none).
  // abort_after: pulse reset after this many words (0 = none).
  task automatic drain(input int b, input int n, input int mode, input int restart_at,
                       input int abort_after);
    logic [15:0] exp_q [$];
    logic [15:0] prev_data;
    logic        prev_last;
    logic        prev_stall;
    int          issued;
    int          popped;
    int          last_hs;
    bit          finished;
    bit          hs;
    logic [3:0]  rb;
    int          pat [4];
    pat = '{1, 0, 0, 1};
    for (int i = 0; i < n; i++) exp_q.push_back(sram[(b + i) % 16]);
    issued = 0; popped = 0; last_hs = 0; finished = 0; prev_stall = 0;
    prev_data = '0; prev_last = 0;
    rb = 4'((b + 5) % 16);

    @(posedge clk); #1;
    start = 1'b1; Base_Addr = 4'(b); Count = 5'(n); out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 300; c++) begin
      if (c == restart_at) begin
        start = 1'b1; Base_Addr = rb; Count = 5'd3;
      end else begin
        start = 1'b0;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = pat[(c - 1) % 4][0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      check("cs_eq_rd", {31'd0, En_Chip_Select}, {31'd0, En_Read});
      check("credit", {31'd0, ((issued - popped) <= 2)}, 1);
      if (c == 1) check("first_rd", {31'd0, En_Read}, {31'd0, (n != 0)});
      if (En_Read) begin
        check("rd_addr", {28'd0, Addr_Read}, (b + issued) % 16);
        issued++;
      end
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 1);
        check("stall_data", {16'd0, out_data}, {16'd0, prev_data});
        check("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      hs = out_valid && out_ready;
      if (hs) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          check("data", {16'd0, out_data}, {16'd0, exp_q[0]});
          check("last", {31'd0, out_last}, {31'd0, (exp_q.size() == 1)});
          if (mode == 0) check("hs_cycle", c, 3 + popped);
          void'(exp_q.pop_front());
        end
        popped++;
        last_hs = c;
      end
      check("busy", {31'd0, busy}, {31'd0, (n != 0 && !done)});
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (abort_after != 0 && popped == abort_after) begin
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        #1 reset_n = 1'b1;
        finished = 1;
        break;
      end
      if (done) begin
        check("remaining", exp_q.size(), 0);
        check("num_reads", issued, n);
        check("done_cycle", c, (n == 0) ? 1 : last_hs + 1);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 0);
        finished = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!finished) check("timeout", 1, 0);
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; Base_Addr = '0; Count = '0; out_ready = 1'b0;
    Read_Data = '0;
    for (int i = 0; i < 16; i++) sram[i] = 16'(i * 3);
    #12;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    drain(0, 16, 0, 0, 0);    // full walk at full rate
    drain(0, 16, 1, 0, 0);    // backpressure 1,0,0,1
    drain(14, 4, 0, 0, 0);    // address wrap 14,15,0,1
    drain(0, 0, 0, 0, 0);     // empty drain
    drain(3, 10, 0, 4, 0);    // competing start mid-drain
    drain(2, 12, 2, 6, 0);    // competing start under random stall
    drain(0, 16, 0, 0, 5);    // reset after 5 words
    drain(7, 5, 0, 0, 0);     // fresh drain after reset

    for (int i = 0; i < 16; i++) sram[i] = 16'($urandom);
    for (int t = 0; t < 12; t++)
      drain(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)),
            int'($urandom_range(0, 2)), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/result_drain.md
# result_drain

Read-side drain engine for the dot-product output SRAM. After a computation pass, it walks the output SRAM from a base address and streams each stored word to the host over a valid/ready interface. It is the counterpart of the file-load path that fills the SRAMs. It sits between the output `Dual_SRAM` read port (1-cycle registered read) and the host/testbench result sink.

## Interface

Parameters:
- `Addr_Width`, 4: SRAM address width.
- `Ram_Depth`, `1 << Addr_Width`: SRAM depth; addresses wrap modulo this value.
- `Nums_Data_in_bits`, 4: width of the word-count field, minus one.
- `Para_Deg`, 1: lanes per SRAM word.
- `Data_Width_Out`, 16: lane width; word width is `Para_Deg*Data_Width_Out`.

Ports:
- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle request to begin a drain. Ignored while `busy`=1.
- `Base_Addr`, in, `Addr_Width`: first read address. Sampled with `start`.
- `Count`, in, `Nums_Data_in_bits+1`: number of words to drain, 0..`1<<Nums_Data_in_bits`. Sampled with `start`.
- `En_Chip_Select`, out, 1: SRAM chip select. Equals `En_Read`.
- `En_Read`, out, 1: SRAM read strobe.
- `Addr_Read`, out, `Addr_Width`: SRAM read address.
- `Read_Data`, in, `Para_Deg*Data_Width_Out`: SRAM data. Valid in the cycle after `En_Read`.
- `out_valid`, out, 1: stream word is valid.
- `out_ready`, in, 1: sink accepts the word.
- `out_data`, out, `Para_Deg*Data_Width_Out`: stream word.
- `out_last`, out, 1: marks the final word of the drain. Qualified by `out_valid`.
- `busy`, out, 1: drain is in progress.
- `done`, out, 1: one-cycle completion pulse.

## Operation

- Reset values (async on `reset_n`=0): state IDLE; `En_Chip_Select`, `En_Read`, `out_valid`, `out_last`, `busy`, `done` = 0; `Addr_Read`, `out_data` = 0; skid FIFO empty; all counters 0. Any in-flight read is discarded, including when reset occurs mid-drain.
- State machine:
  - IDLE: on `start` with `Count`>0, latch address and count, go to ISSUE. On `start` with `Count`=0, go to DONE; no reads are issued.
  - ISSUE: issue reads while credits allow. When the final read is issued, go to FLUSH.
  - FLUSH: wait until the FIFO is empty and no read is in flight, then go to DONE.
  - DONE: assert `done` for one cycle, then go to IDLE.
- `busy` = 1 in ISSUE and FLUSH.
- Buffering: a 2-entry skid FIFO holds returned words. Each `Read_Data` return is pushed in the cycle it is valid; the SRAM cannot be stalled.
- Credit rule: a read is issued in a cycle iff `occupancy + inflight - pop < 2`, where `pop` = `out_valid & out_ready`. This guarantees the FIFO never overflows.
- Addressing: the first read uses `Base_Addr`. Each later read uses the previous address + 1 modulo `Ram_Depth` (for example 15 -> 0 when `Addr_Width`=4).
- Issue counter: counts down from `Count`. `out_last` is a per-entry tag set on the word read with issue count = 1.
- Stream output: `out_data`/`out_valid` present the FIFO head. While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable and `out_valid` stays high.
- `start` during `busy` has no effect; the latched `Base_Addr`/`Count` are unchanged.
- `Count` greater than `Ram_Depth` is legal; the address wraps and SRAM words are re-read.

## Timing

- Let E0 be the edge that samples `start`:
  - `En_Read`=1 with `Addr_Read`=`Base_Addr` in the cycle after E0.
  - `Read_Data` is valid in the next cycle and pushed at that cycle's end.
  - `out_valid`=1 in the third cycle after E0.
  - Start-to-first-word latency: 3 cycles.
- With `out_ready` held at 1, throughput is 1 word per cycle. N words end with the `out_last` handshake at cycle N+2 after E0.
- `done` is asserted in the cycle after the last-word handshake. `busy` deasserts in the same cycle that `done` asserts.
- `Count`=0: `done` pulses in the cycle after E0. `En_Read` and `out_valid` never assert.
- Simultaneous push and pop on a full FIFO is legal; occupancy stays at 2.

## Test plan

- Preload SRAM[i]=i*3. Drive `start`, `Base_Addr`=0, `Count`=16, `out_ready`=1 -> outputs 0,3,…,45 on 16 consecutive cycles starting 3 cycles after start; `out_last` only on 45; `done` pulse on the following cycle.
- Same preload with `out_ready` toggling 1,0,0,1 -> identical sequence with no loss or duplication; `out_data` is stable while stalled; `inflight + occupancy` never exceeds 2.
- `Base_Addr`=14, `Count`=4 -> read addresses 14,15,0,1; data 42,45,0,3.
- `Count`=0 -> `done` one cycle after start; `En_Read` and `out_valid` stay 0.
- `start` pulsed again mid-drain with different `Base_Addr`/`Count` -> ignored; the original sequence completes unchanged.
- `reset_n` asserted low after 5 of 16 words -> all outputs drop to their reset values immediately; after release, a fresh `start` drains correctly from the new `Base_Addr`.
